// File: rtl/scr1_tapc_edge_sampler.sv
// scr1_tapc_edge_sampler: samples raw TCK and a TCK-domain bundle in the clk domain, emits TCK edge pulses, captures the bundle into a FIFO on each TCK rise
// Ports: clk/rst_n (async active-low); tck_async, data_async raw inputs;
//   tck_rise_pulse/tck_fall_pulse one-cycle edge pulses; fifo_rdata/fifo_valid/fifo_ready/fifo_level capture FIFO;
//   overflow sticky drop flag cleared by ovf_clr; edge_cnt wrapping count of rises.
// Optional glitch filter enabled by defining SCR1_TAPC_SYNC_FILTER_EN.
module scr1_tapc_edge_sampler #(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_W      = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int FILT_CYCLES = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          tck_async,
  input  logic [DATA_W-1:0]             data_async,
  output logic                          tck_rise_pulse,
  output logic                          tck_fall_pulse,
  output logic [DATA_W-1:0]             fifo_rdata,
  output logic                          fifo_valid,
  input  logic                          fifo_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  input  logic                          ovf_clr,
  output logic [15:0]                   edge_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
`ifdef SCR1_TAPC_SYNC_FILTER_EN
  localparam int PRIME = SYNC_STAGES + 1 + FILT_CYCLES;
`else
  localparam int PRIME = SYNC_STAGES + 1;
`endif
  localparam int IW = $clog2(PRIME + 1);
  logic [SYNC_STAGES-1:0] s_tck_q;
  logic [DATA_W-1:0]      s_data_q [SYNC_STAGES];
  logic                   tck_lvl, tck_lvl_q, rise_q, fall_q;
  logic                   primed, rise, fall, pop, push;
  logic [IW-1:0]          init_q;
  logic [DATA_W-1:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]          level_q, level_d;
  logic                   ovf_q, ovf_d;
  logic [15:0]            edge_cnt_q, edge_cnt_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s_tck_q <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) s_data_q[i] <= '0;
    end else begin
      s_tck_q     <= {s_tck_q[SYNC_STAGES-2:0], tck_async};
      s_data_q[0] <= data_async;
      for (int i = 1; i < SYNC_STAGES; i++) s_data_q[i] <= s_data_q[i-1];
    end
`ifdef SCR1_TAPC_SYNC_FILTER_EN
  localparam int CW = $clog2(FILT_CYCLES + 1);
  logic          filt_q, filt_d, diff, hit;
  logic [CW-1:0] fcnt_q, fcnt_d;
  // level flips only after the sync output has disagreed for FILT_CYCLES consecutive cycles
  assign diff    = s_tck_q[SYNC_STAGES-1] ^ filt_q;
  assign hit     = diff & (fcnt_q == CW'(FILT_CYCLES - 1));
  assign filt_d  = filt_q ^ hit;
  assign fcnt_d  = (!diff || hit) ? '0 : fcnt_q + 1'b1;
  assign tck_lvl = filt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      filt_q <= 1'b0;
      fcnt_q <= '0;
    end else begin
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
    end
`else
  assign tck_lvl = s_tck_q[SYNC_STAGES-1];
`endif
  // until primed, tck_lvl_q silently follows tck_lvl so the level at reset release never yields an edge
  assign primed     = init_q == IW'(PRIME);
  assign rise       = primed & tck_lvl & ~tck_lvl_q;
  assign fall       = primed & ~tck_lvl & tck_lvl_q;
  assign pop        = (level_q != '0) & fifo_ready;
  assign push       = rise & ((level_q != LW'(FIFO_DEPTH)) | pop);
  assign level_d    = level_q + LW'(push) - LW'(pop);
  assign ovf_d      = (rise & ~push) | (ovf_q & ~ovf_clr);
  assign edge_cnt_d = edge_cnt_q + 16'(rise);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      init_q     <= '0;
      tck_lvl_q  <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ovf_q      <= 1'b0;
      edge_cnt_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      init_q     <= primed ? init_q : init_q + 1'b1;
      tck_lvl_q  <= tck_lvl;
      rise_q     <= rise;
      fall_q     <= fall;
      level_q    <= level_d;
      ovf_q      <= ovf_d;
      edge_cnt_q <= edge_cnt_d;
      if (push) begin
        mem_q[wr_ptr_q] <= s_data_q[SYNC_STAGES-1];
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  assign tck_rise_pulse = rise_q;
  assign tck_fall_pulse = fall_q;
  assign fifo_valid     = level_q != '0;
  assign fifo_rdata     = fifo_valid ? mem_q[rd_ptr_q] : '0;
  assign fifo_level     = level_q;
  assign overflow       = ovf_q;
  assign edge_cnt       = edge_cnt_q;
endmodule

// File: tb/tb_scr1_tapc_edge_sampler.sv
// tb_scr1_tapc_edge_sampler: directed plus random stimulus against a queue-based edge/FIFO reference model
module tb_scr1_tapc_edge_sampler;
  localparam int S = 2;
  localparam int DEPTH = 4;
`ifdef SCR1_TAPC_SYNC_FILTER_EN
  localparam int F = 2;
`else
  localparam int F = 0;
`endif
  localparam int LAT = S + F;
  localparam int PRIME = S + 1 + F;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tck_async = 1'b0;
  logic [7:0] data_async = 8'h00;
  logic       fifo_ready = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       tck_rise_pulse, tck_fall_pulse, fifo_valid, overflow;
  logic [7:0] fifo_rdata;
  logic [2:0] fifo_level;
  logic [15:0] edge_cnt;
  scr1_tapc_edge_sampler #(.SYNC_STAGES(S), .DATA_W(8), .FIFO_DEPTH(DEPTH), .FILT_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .tck_async(tck_async), .data_async(data_async),
    .tck_rise_pulse(tck_rise_pulse), .tck_fall_pulse(tck_fall_pulse),
    .fifo_rdata(fifo_rdata), .fifo_valid(fifo_valid), .fifo_ready(fifo_ready),
    .fifo_level(fifo_level), .overflow(overflow), .ovf_clr(ovf_clr), .edge_cnt(edge_cnt)
  );
  always #5 clk = ~clk;
  int         vectors = 0;
  int         miscompares = 0;
  int         n = 0;
  int         rel_n = 1 << 30;
  int         rise_due[$];
  int         fall_due[$];
  logic [7:0] rise_dat[$];
  logic [7:0] mq[$];
  logic       m_ovf = 1'b0;
  logic [15:0] m_cnt = '0;
  bit         rand_mode = 0;
  int         rdy_bias = 4;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic clear_model();
    rise_due.delete();
    fall_due.delete();
    rise_dat.delete();
    mq.delete();
    m_ovf = 1'b0;
    m_cnt = '0;
    rel_n = 1 << 30;
  endtask
  // a TCK change applied now is captured at edge n+1 and must surface LAT edges later, unless still priming
  task automatic drive_tck(bit v);
    int due;
    due = n + 1 + LAT;
    if (v != tck_async && due > rel_n + PRIME) begin
      if (v) begin
        rise_due.push_back(due);
        rise_dat.push_back(data_async);
      end else fall_due.push_back(due);
    end
    tck_async = v;
  endtask
  task automatic step();
    bit r, f, pop, push;
    logic [7:0] d;
    r = 0;
    f = 0;
    d = '0;
    @(posedge clk);
    #1;
    n++;
    if (rst_n) begin
      r = rise_due.size() != 0 && rise_due[0] == n;
      if (r) begin
        void'(rise_due.pop_front());
        d = rise_dat.pop_front();
      end
      f = fall_due.size() != 0 && fall_due[0] == n;
      if (f) void'(fall_due.pop_front());
      pop = mq.size() != 0 && fifo_ready;
      push = r && (mq.size() < DEPTH || pop);
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(d);
      m_ovf = (r && !push) ? 1'b1 : (ovf_clr ? 1'b0 : m_ovf);
      if (r) m_cnt++;
    end
    chk("rise_pulse", tck_rise_pulse, r);
    chk("fall_pulse", tck_fall_pulse, f);
    chk("valid", fifo_valid, mq.size() != 0);
    chk("level", fifo_level, mq.size());
    chk("rdata", fifo_rdata, mq.size() != 0 ? mq[0] : 8'h00);
    chk("overflow", overflow, m_ovf);
    chk("edge_cnt", edge_cnt, m_cnt);
  endtask
  task automatic run(int c);
    for (int i = 0; i < c; i++) begin
      if (rand_mode) begin
        fifo_ready = $urandom_range(0, 3) < rdy_bias;
        ovf_clr = $urandom_range(0, 15) == 0;
      end
      step();
    end
  endtask
  task automatic period(logic [7:0] d, int lo, int hi);
    data_async = d;
    run(lo);
    drive_tck(1);
    run(hi);
    drive_tck(0);
  endtask
  task automatic do_reset(int hold);
    rst_n = 1'b0;
    clear_model();
    #1;
    chk("rst_level", fifo_level, 0);
    chk("rst_cnt", edge_cnt, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_valid", fifo_valid, 0);
    run(hold);
    rst_n = 1'b1;
    rel_n = n;
  endtask
  initial begin
    logic [15:0] cnt_before;
    clear_model();
    run(3);
    rst_n = 1'b1;
    rel_n = n;
    run(PRIME + 4);
    // three TCK periods, consumer always ready
    fifo_ready = 1'b1;
    period(8'h11, 8, 8);
    period(8'h22, 8, 8);
    period(8'h33, 8, 8);
    run(12);
    chk("t1_edge_cnt", edge_cnt, 3);
    chk("t1_overflow", overflow, 0);
    // five rises into a depth-4 FIFO with no consumer
    fifo_ready = 1'b0;
    for (int i = 0; i < 5; i++) period(8'hA0 + 8'(i), 8, 8);
    run(10);
    chk("t2_level_full", fifo_level, 4);
    chk("t2_overflow", overflow, 1);
    fifo_ready = 1'b1;
    run(6);
    chk("t2_drained", fifo_level, 0);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("t2_ovf_clr", overflow, 0);
    // full FIFO with a pop landing exactly on the rise edge
    fifo_ready = 1'b0;
    for (int i = 0; i < 4; i++) period(8'hB0 + 8'(i), 8, 8);
    data_async = 8'hC0;
    run(8);
    drive_tck(1);
    repeat (LAT) step();
    fifo_ready = 1'b1;
    step();
    fifo_ready = 1'b0;
    chk("t3_level", fifo_level, 4);
    chk("t3_overflow", overflow, 0);
    chk("t3_head", fifo_rdata, 8'hB1);
    run(8);
    drive_tck(0);
    run(8);
    fifo_ready = 1'b1;
    run(8);
    // TCK held high across reset release
    do_reset(0);
    rst_n = 1'b0;
    drive_tck(1);
    run(3);
    rst_n = 1'b1;
    rel_n = n;
    run(PRIME + 6);
    chk("t5_no_capture", edge_cnt, 0);
    data_async = 8'h5A;
    drive_tck(0);
    run(8);
    drive_tck(1);
    run(8);
    drive_tck(0);
    run(10);
    chk("t5_one_rise", edge_cnt, 1);
`ifdef SCR1_TAPC_SYNC_FILTER_EN
    // short glitches must be swallowed, a 3-cycle pulse must pass
    cnt_before = m_cnt;
    drive_tck(1);
    step();
    drive_tck(0);
    void'(rise_due.pop_back());
    void'(rise_dat.pop_back());
    void'(fall_due.pop_back());
    run(12);
    chk("t4_glitch_cnt", edge_cnt, cnt_before);
    drive_tck(1);
    repeat (3) step();
    drive_tck(0);
    run(12);
    chk("t4_wide_cnt", edge_cnt, cnt_before + 16'd1);
`endif
    // counter wrap
    cnt_before = 16'hFFFF;
    force dut.edge_cnt_q = 16'hFFFF;
    m_cnt = cnt_before;
    step();
    release dut.edge_cnt_q;
    step();
    period(8'h77, 8, 8);
    run(10);
    chk("t6_wrap", edge_cnt, 16'h0000);
    // overflowing burst interrupted by reset
    fifo_ready = 1'b0;
    for (int i = 0; i < 5; i++) period(8'hD0 + 8'(i), 8, 8);
    data_async = 8'hEE;
    run(8);
    drive_tck(1);
    run(3);
    do_reset(2);
    run(PRIME + 6);
    drive_tck(0);
    run(10);
    // randomized TCK timing, data, ready and ovf_clr
    rand_mode = 1;
    for (int i = 0; i < 60; i++) begin
      rdy_bias = $urandom_range(0, 4);
      period(8'($urandom), $urandom_range(6, 12), $urandom_range(6, 12));
    end
    rand_mode = 0;
    fifo_ready = 1'b1;
    ovf_clr = 1'b0;
    run(20);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
